// File: rtl/tsen_scan_ctrl.sv
// Round-robin scan sequencer for NumCh temperature-sensor macros: register block,
// per-channel start/done/timeout handling, threshold compare and a level interrupt.
module tsen_scan_ctrl #(
    parameter int NumCh = 4,
    parameter int DataW = 16,
    parameter int AW    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   re_i,
    input  logic                   we_i,
    input  logic [AW-1:0]          addr_i,
    input  logic [31:0]            wdata_i,
    input  logic [3:0]             be_i,
    output logic [31:0]            rdata_o,
    output logic                   error_o,
    output logic [NumCh-1:0]       tsen_start_o,
    input  logic [NumCh-1:0]       tsen_done_i,
    input  logic [NumCh*DataW-1:0] tsen_data_i,
    output logic                   intr_o,
    output logic                   busy_o
);

    localparam int CW = (NumCh > 1) ? $clog2(NumCh) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, NEXT} state_e;

    state_e             state;
    logic [CW-1:0]      ch;
    logic [15:0]        cnt;

    logic               ctrl_en;
    logic               ctrl_cont;
    logic [NumCh-1:0]   ch_en;
    logic [2:0]         intr_state;
    logic [2:0]         intr_enable;
    logic [DataW-1:0]   thresh;
    logic [15:0]        tmo_cyc;
    logic [DataW-1:0]   data_val [NumCh];
    logic [NumCh-1:0]   data_vld;

    logic [31:0]        addr32;
    logic               aligned;
    logic               is_ctrl, is_chen, is_istate, is_ienable, is_thresh, is_tmo, is_data;
    logic               mapped, wr_ok;
    logic [CW-1:0]      data_idx;
    logic               en_eff, cont_eff, go;

    logic [DataW-1:0]   sens_data [NumCh];
    logic [DataW-1:0]   cur_data;
    logic               cur_done;
    logic               tmo_hit;
    logic [CW-1:0]      first_idx, next_idx;
    logic               first_ok, next_ok;
    logic [2:0]         hw_set;
    logic               unused_bits;

    assign addr32    = 32'(addr_i);
    assign aligned   = (addr32[1:0] == 2'b00);
    assign is_ctrl    = aligned && (addr32 == 32'h00);
    assign is_chen    = aligned && (addr32 == 32'h04);
    assign is_istate  = aligned && (addr32 == 32'h08);
    assign is_ienable = aligned && (addr32 == 32'h0C);
    assign is_thresh  = aligned && (addr32 == 32'h10);
    assign is_tmo     = aligned && (addr32 == 32'h14);
    assign is_data    = aligned && (addr32 >= 32'h40) && (addr32 < 32'h40 + 32'(4 * NumCh));
    assign data_idx   = CW'((addr32 - 32'h40) >> 2);
    assign mapped     = is_ctrl | is_chen | is_istate | is_ienable | is_thresh | is_tmo | is_data;

    // Errors block the access entirely: no register update and rdata forced to 0.
    assign error_o = (re_i | we_i) && (!mapped || (we_i && (is_data || be_i != 4'hF)));
    assign wr_ok   = we_i && !error_o;

    // The FSM sees a CTRL write in the same cycle, so EN|GO starts a scan at once
    // and an EN clear stops it on the very next edge.
    assign en_eff   = (wr_ok && is_ctrl) ? wdata_i[0] : ctrl_en;
    assign cont_eff = (wr_ok && is_ctrl) ? wdata_i[1] : ctrl_cont;
    assign go       = wr_ok && is_ctrl && wdata_i[2];

    assign unused_bits = ^wdata_i;

    always_comb begin
        rdata_o = '0;
        if (re_i && !error_o) begin
            if (is_ctrl)    rdata_o[1:0]       = {ctrl_cont, ctrl_en};
            if (is_chen)    rdata_o[NumCh-1:0] = ch_en;
            if (is_istate)  rdata_o[2:0]       = intr_state;
            if (is_ienable) rdata_o[2:0]       = intr_enable;
            if (is_thresh)  rdata_o[DataW-1:0] = thresh;
            if (is_tmo)     rdata_o[15:0]      = tmo_cyc;
            if (is_data) begin
                rdata_o[DataW-1:0] = data_val[data_idx];
                rdata_o[31]        = data_vld[data_idx];
            end
        end
    end

    for (genvar g = 0; g < NumCh; g++) begin : g_unpack
        assign sens_data[g] = tsen_data_i[g*DataW +: DataW];
    end

    // Sensor protocol: the FSM pulses tsen_start_o[ch] for one cycle and then only
    // listens to tsen_done_i[ch]; data is taken in the cycle done is high.
    assign cur_data = sens_data[ch];
    assign cur_done = tsen_done_i[ch];
    assign tmo_hit  = (tmo_cyc != 16'd0) && (cnt == tmo_cyc - 16'd1);

    always_comb begin
        first_idx = '0;
        next_idx  = '0;
        first_ok  = |ch_en;
        next_ok   = 1'b0;
        for (int i = NumCh - 1; i >= 0; i--) begin
            if (ch_en[i]) first_idx = CW'(i);
            if (ch_en[i] && (i > int'(ch))) begin
                next_ok  = 1'b1;
                next_idx = CW'(i);
            end
        end
    end

    always_comb begin
        hw_set    = 3'b000;
        hw_set[0] = (state == NEXT) && en_eff && !next_ok;
        hw_set[1] = (state == WAIT) && en_eff && cur_done && (cur_data > thresh);
        hw_set[2] = (state == WAIT) && en_eff && !cur_done && tmo_hit;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_en     <= 1'b0;
            ctrl_cont   <= 1'b0;
            ch_en       <= '0;
            intr_state  <= '0;
            intr_enable <= '0;
            thresh      <= '0;
            tmo_cyc     <= '0;
        end else begin
            if (wr_ok && is_ctrl) begin
                ctrl_en   <= wdata_i[0];
                ctrl_cont <= wdata_i[1];
            end
            if (wr_ok && is_chen)    ch_en       <= wdata_i[NumCh-1:0];
            if (wr_ok && is_ienable) intr_enable <= wdata_i[2:0];
            if (wr_ok && is_thresh)  thresh      <= wdata_i[DataW-1:0];
            if (wr_ok && is_tmo)     tmo_cyc     <= wdata_i[15:0];
            // Hardware set wins over a simultaneous W1C of the same bit.
            if (wr_ok && is_istate) intr_state <= (intr_state & ~wdata_i[2:0]) | hw_set;
            else                    intr_state <= intr_state | hw_set;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            ch       <= '0;
            cnt      <= '0;
            data_vld <= '0;
            for (int i = 0; i < NumCh; i++) data_val[i] <= '0;
        end else if (state != IDLE && !en_eff) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (en_eff && first_ok && (go || cont_eff)) begin
                        ch    <= first_idx;
                        state <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (cur_done) begin
                        data_val[ch] <= cur_data;
                        data_vld[ch] <= 1'b1;
                        state        <= NEXT;
                    end else if (tmo_hit) begin
                        data_vld[ch] <= 1'b0;
                        state        <= NEXT;
                    end
                end
                NEXT: begin
                    if (next_ok) begin
                        ch    <= next_idx;
                        state <= START;
                    end else if (cont_eff && first_ok) begin
                        ch    <= first_idx;
                        state <= START;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        tsen_start_o = '0;
        if (state == START) tsen_start_o[ch] = 1'b1;
    end

    assign busy_o = (state != IDLE);
    assign intr_o = |(intr_state & intr_enable);

endmodule

// File: tb/tb_tsen_scan_ctrl.sv
// Bench for tsen_scan_ctrl: scenario tasks plus randomized scans checked against
// a scan-order/latency model built from the channel-enable list and response delays.
module tb_tsen_scan_ctrl;

    localparam int NumCh = 4;
    localparam int DataW = 16;
    localparam int AW    = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   re, we;
    logic [AW-1:0]          addr;
    logic [31:0]            wdata;
    logic [3:0]             be;
    logic [31:0]            rdata;
    logic                   error;
    logic [NumCh-1:0]       tsen_start;
    logic [NumCh-1:0]       tsen_done;
    logic [NumCh*DataW-1:0] tsen_data;
    logic                   intr;
    logic                   busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DataW-1:0] m_val [NumCh];
    logic             m_vld [NumCh];
    int               sc_dly [NumCh];
    logic [DataW-1:0] sc_val [NumCh];
    logic             wr_err_last;

    tsen_scan_ctrl #(.NumCh(NumCh), .DataW(DataW), .AW(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .re_i(re), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .rdata_o(rdata), .error_o(error),
        .tsen_start_o(tsen_start), .tsen_done_i(tsen_done), .tsen_data_i(tsen_data),
        .intr_o(intr), .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // All driver tasks start and end on a falling edge.
    task automatic reg_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b,
                             output logic err);
        addr = a; wdata = d; be = b; we = 1'b1;
        #1 err = error;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic reg_read(input logic [7:0] a, output logic [31:0] d, output logic err);
        addr = a; re = 1'b1;
        #1 d = rdata; err = error;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        reg_write(a, d, 4'hF, wr_err_last);
    endtask

    task automatic test_reset();
        logic [7:0]  addrs [10];
        logic [31:0] rd;
        logic        err;
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h40, 8'h44, 8'h48, 8'h4C};
        rst_n = 1'b0; re = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        tsen_done = '0; tsen_data = '0;
        for (int i = 0; i < NumCh; i++) begin m_val[i] = '0; m_vld[i] = 1'b0; end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({busy, intr, tsen_start} !== 6'b0)
            $display("FAIL reset_outputs: got busy=%b intr=%b start=%b required 0", busy, intr, tsen_start);
        for (int i = 0; i < 10; i++) begin
            reg_read(addrs[i], rd, err);
            n_tests++;
            if (rd !== 32'h0 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_reg[%h]: got %h err=%b required 0 err=0", addrs[i], rd, err);
            end
        end
        reg_read(8'h18, rd, err);
        n_tests++;
        if (rd !== 32'h0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL unmapped_read: got %h err=%b required 0 err=1", rd, err);
        end
    endtask

    // One-shot scan: expected start order is the ascending enabled list; each channel
    // occupies 1 + (response delay or timeout) + 1 cycles before the next start.
    task automatic run_scan(input logic [3:0] chen, input logic [15:0] thr, input int tmo,
                            input bit noise);
        int          q[$];
        int          exp_start, act, w, done_cyc, end_cyc, j;
        bit          exp_over, exp_to, finished;
        logic [3:0]  exp_pat;
        logic [31:0] rd;
        logic        err;
        wr(8'h08, 32'h7); wr(8'h0C, 32'h7); wr(8'h04, 32'(chen));
        wr(8'h10, 32'(thr)); wr(8'h14, 32'(tmo));
        exp_over = 1'b0; exp_to = 1'b0;
        for (int i = 0; i < NumCh; i++) begin
            if (chen[i]) begin
                q.push_back(i);
                if (sc_dly[i] != 0) begin
                    m_val[i] = sc_val[i]; m_vld[i] = 1'b1;
                    if (sc_val[i] > thr) exp_over = 1'b1;
                end else begin
                    m_vld[i] = 1'b0; exp_to = 1'b1;
                end
            end
        end
        wr(8'h00, 32'h5);
        exp_start = 0; act = -1; done_cyc = -1; end_cyc = -1; finished = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tsen_done = '0;
            exp_pat = (q.size() > 0 && cyc == exp_start) ? (4'b0001 << q[0]) : 4'b0000;
            if (exp_pat != 4'b0000 || tsen_start != 4'b0000) begin
                n_tests++;
                if (tsen_start !== exp_pat) begin
                    n_fail++;
                    $display("FAIL start_pulse cyc=%0d: got %b required %b", cyc, tsen_start, exp_pat);
                end
            end
            if (exp_pat != 4'b0000) begin
                act = q.pop_front();
                w = (sc_dly[act] != 0) ? sc_dly[act] : tmo;
                done_cyc = (sc_dly[act] != 0) ? cyc + sc_dly[act] : -1;
                exp_start = cyc + w + 2;
                if (q.size() == 0) end_cyc = cyc + w + 2;
            end
            if (cyc == done_cyc) begin
                tsen_done[act] = 1'b1;
                tsen_data[act*DataW +: DataW] = sc_val[act];
            end else if (noise && act >= 0 && $urandom_range(0, 3) == 0) begin
                j = $urandom_range(0, NumCh - 1);
                if (j != act) begin
                    tsen_done[j] = 1'b1;
                    tsen_data[j*DataW +: DataW] = 16'($urandom);
                end
            end
            if (cyc == end_cyc - 1) begin
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_last_next cyc=%0d: got %b required 1", cyc, busy);
                end
            end
            if (cyc == end_cyc) begin
                n_tests++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_end cyc=%0d: got %b required 0", cyc, busy);
                end
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tsen_done = '0;
        n_tests++;
        if (!finished) begin
            n_fail++;
            $display("FAIL scan_budget: got unfinished scan, %0d starts missing, required completion", q.size());
        end
        for (int i = 0; i < NumCh; i++) begin
            reg_read(8'h40 + 8'(4 * i), rd, err);
            n_tests++;
            if (rd !== {m_vld[i], 15'd0, m_val[i]}) begin
                n_fail++;
                $display("FAIL data[%0d]: got %h required %h", i, rd, {m_vld[i], 15'd0, m_val[i]});
            end
        end
        reg_read(8'h08, rd, err);
        n_tests++;
        if (rd !== {29'd0, exp_to, exp_over, 1'b1} || intr !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_intr: got state=%h intr=%b required %h intr=1", rd, intr,
                     {29'd0, exp_to, exp_over, 1'b1});
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        logic        err;
        sc_dly = '{0, 2, 0, 4};
        sc_val = '{16'd0, 16'd50, 16'd0, 16'd200};
        run_scan(4'b1010, 16'd100, 0, 1'b0);
        reg_read(8'h44, rd, err);
        n_tests++;
        if (rd !== 32'h80000032) begin
            n_fail++; $display("FAIL basic_data1: got %h required 80000032", rd);
        end
        reg_read(8'h4C, rd, err);
        n_tests++;
        if (rd !== 32'h800000C8) begin
            n_fail++; $display("FAIL basic_data3: got %h required 800000c8", rd);
        end
        reg_read(8'h08, rd, err);
        n_tests++;
        if (rd !== 32'h3) begin
            n_fail++; $display("FAIL basic_intr_state: got %h required 3", rd);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        logic        err;
        wr(8'h08, 32'h7); wr(8'h0C, 32'h4); wr(8'h04, 32'h1); wr(8'h14, 32'd5);
        wr(8'h00, 32'h5);
        for (int cyc = 0; cyc <= 7; cyc++) begin
            if (cyc == 0) begin
                n_tests++;
                if (tsen_start !== 4'b0001) begin
                    n_fail++; $display("FAIL tmo_start: got %b required 0001", tsen_start);
                end
            end
            if (cyc == 5 || cyc == 6) begin
                n_tests++;
                if (intr !== (cyc == 6)) begin
                    n_fail++; $display("FAIL tmo_intr_timing cyc=%0d: got %b required %b", cyc, intr, cyc == 6);
                end
            end
            if (cyc == 7) begin
                n_tests++;
                if (busy !== 1'b0) begin
                    n_fail++; $display("FAIL tmo_busy: got %b required 0", busy);
                end
            end
            if (cyc < 7) @(negedge clk);
        end
        m_vld[0] = 1'b0;
        reg_read(8'h40, rd, err);
        n_tests++;
        if (rd !== {1'b0, 15'd0, m_val[0]}) begin
            n_fail++; $display("FAIL tmo_data0: got %h required %h", rd, {1'b0, 15'd0, m_val[0]});
        end
        reg_read(8'h08, rd, err);
        n_tests++;
        if (rd !== 32'h5) begin
            n_fail++; $display("FAIL tmo_intr_state: got %h required 5", rd);
        end
    endtask

    task automatic test_continuous();
        logic [31:0] rd;
        logic        err;
        logic [3:0]  exp_pat;
        wr(8'h10, 32'hFFFF); wr(8'h14, 32'h0); wr(8'h04, 32'h1); wr(8'h0C, 32'h7);
        wr(8'h08, 32'h7); wr(8'h00, 32'h7);
        for (int cyc = 0; cyc <= 30; cyc++) begin
            tsen_done = '0; we = 1'b0;
            exp_pat = (cyc % 5 == 0 && cyc <= 20) ? 4'b0001 : 4'b0000;
            if (exp_pat != 4'b0000 || tsen_start != 4'b0000) begin
                n_tests++;
                if (tsen_start !== exp_pat) begin
                    n_fail++; $display("FAIL cont_start cyc=%0d: got %b required %b", cyc, tsen_start, exp_pat);
                end
            end
            if (cyc % 5 == 3 && cyc < 20) begin
                tsen_done[0] = 1'b1; tsen_data[15:0] = 16'h1000 + 16'(cyc);
            end
            if (cyc == 5 || cyc == 25) begin
                n_tests++;
                if (intr !== (cyc == 5)) begin
                    n_fail++; $display("FAIL cont_intr cyc=%0d: got %b required %b", cyc, intr, cyc == 5);
                end
            end
            if (cyc == 21) begin
                addr = 8'h08; wdata = 32'h7; be = 4'hF; we = 1'b1;
            end
            if (cyc == 22) begin
                tsen_done[0] = 1'b1; tsen_data[15:0] = 16'hBEEF;
                addr = 8'h00; wdata = 32'h0; be = 4'hF; we = 1'b1;
            end
            if (cyc == 21 || cyc == 23) begin
                n_tests++;
                if (busy !== (cyc == 21)) begin
                    n_fail++; $display("FAIL cont_busy cyc=%0d: got %b required %b", cyc, busy, cyc == 21);
                end
            end
            @(negedge clk);
        end
        tsen_done = '0; we = 1'b0;
        m_val[0] = 16'h1012; m_vld[0] = 1'b1;
        reg_read(8'h08, rd, err);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL cont_stop_intr: got %h required 0", rd);
        end
        reg_read(8'h40, rd, err);
        n_tests++;
        if (rd !== 32'h80001012) begin
            n_fail++; $display("FAIL cont_stop_data: got %h required 80001012", rd);
        end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] rd;
        logic        err;
        wr(8'h08, 32'h7); wr(8'h04, 32'h1); wr(8'h14, 32'h0); wr(8'h10, 32'hFFFF);
        wr(8'h00, 32'h5);
        for (int cyc = 0; cyc <= 3; cyc++) begin
            tsen_done = '0; we = 1'b0;
            if (cyc == 1) begin
                tsen_done[0] = 1'b1; tsen_data[15:0] = 16'h0005;
            end
            if (cyc == 2) begin
                addr = 8'h08; wdata = 32'h1; be = 4'hF; we = 1'b1;
            end
            if (cyc == 3) begin
                n_tests++;
                if (busy !== 1'b0) begin
                    n_fail++; $display("FAIL w1c_busy: got %b required 0", busy);
                end
            end
            @(negedge clk);
        end
        tsen_done = '0; we = 1'b0;
        m_val[0] = 16'h0005; m_vld[0] = 1'b1;
        reg_read(8'h08, rd, err);
        n_tests++;
        if (rd !== 32'h1) begin
            n_fail++; $display("FAIL w1c_collision: got %h required 1", rd);
        end
        wr(8'h08, 32'h1);
        reg_read(8'h08, rd, err);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL w1c_clear: got %h required 0", rd);
        end
    endtask

    task automatic test_random_scans();
        int tmo;
        for (int it = 0; it < 8; it++) begin
            tmo = $urandom_range(1, 8);
            for (int i = 0; i < NumCh; i++) begin
                sc_val[i] = 16'($urandom);
                sc_dly[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, tmo);
            end
            run_scan(4'($urandom_range(1, 15)), 16'($urandom), tmo, 1'b1);
        end
    endtask

    task automatic test_access_errors();
        logic [31:0] rd;
        logic        err;
        wr(8'h00, 32'h2);
        reg_write(8'h00, 32'h1, 4'h1, err);
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL be_partial_err: got %b required 1", err);
        end
        reg_read(8'h00, rd, err);
        n_tests++;
        if (rd !== 32'h2 || busy !== 1'b0) begin
            n_fail++; $display("FAIL be_partial_ctrl: got %h busy=%b required 2 busy=0", rd, busy);
        end
        reg_write(8'h40, 32'h0, 4'hF, err);
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL data_write_err: got %b required 1", err);
        end
        reg_read(8'h40, rd, err);
        n_tests++;
        if (rd !== {m_vld[0], 15'd0, m_val[0]}) begin
            n_fail++; $display("FAIL data_write_kept: got %h required %h", rd, {m_vld[0], 15'd0, m_val[0]});
        end
        reg_read(8'h02, rd, err);
        n_tests++;
        if (rd !== 32'h0 || err !== 1'b1) begin
            n_fail++; $display("FAIL unaligned_read: got %h err=%b required 0 err=1", rd, err);
        end
        reg_write(8'h20, 32'h1, 4'hF, err);
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL unmapped_write: got %b required 1", err);
        end
        wr(8'h04, 32'h0); wr(8'h00, 32'h5);
        n_tests++;
        if (busy !== 1'b0 || tsen_start !== 4'b0) begin
            n_fail++; $display("FAIL go_no_channels: got busy=%b start=%b required 0", busy, tsen_start);
        end
        reg_read(8'h00, rd, err);
        n_tests++;
        if (rd !== 32'h1) begin
            n_fail++; $display("FAIL go_reads_zero: got %h required 1", rd);
        end
        wr(8'h00, 32'h0);
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        logic        err;
        wr(8'h04, 32'h1); wr(8'h14, 32'h0); wr(8'h00, 32'h7);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || tsen_start !== 4'b0 || intr !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got busy=%b start=%b intr=%b required 0", busy, tsen_start, intr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NumCh; i++) begin m_val[i] = '0; m_vld[i] = 1'b0; end
        reg_read(8'h00, rd, err);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL async_reset_ctrl: got %h required 0", rd);
        end
        reg_read(8'h04, rd, err);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL async_reset_chen: got %h required 0", rd);
        end
        reg_read(8'h40, rd, err);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL async_reset_data0: got %h required 0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_continuous();
        test_w1c_collision();
        test_random_scans();
        test_access_errors();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
